// File: rtl/sram_req_ctrl_if.sv
// Request, response and SRAM-port signal bundle for sram_req_ctrl.
// slave is the controller's view; master is the requester/SRAM side.
interface sram_req_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [3:0]        req_be;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport slave (
        input  req_valid, req_wr, req_be, req_addr, req_wdata, rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output req_valid, req_wr, req_be, req_addr, req_wdata, rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Request-side sequencer for a single-port word SRAM with byte-enabled requests.
// Define SRAM_REQ_CTRL_RMW_EN to perform partial writes as read-modify-write; otherwise they are rejected with rsp_err.
module sram_req_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          reset,
    sram_req_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RMW_RD  = 3'd2,
        RMW_WR  = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              rspValid_q;
    logic [31:0]       rspRdata_q;
    logic              rspErr_q;

    logic              reqReady;
    logic              accept;
    logic [ADDR_W-1:0] reqWordAddr;
    logic              rspSet;
    logic [31:0]       rspData;
    logic              rspErrSet;
    logic              sramEn;
    logic [3:0]        sramWen;
    logic [ADDR_W-1:0] sramAddr;
    logic [31:0]       sramWdata;
    logic              unusedAddrBits;

`ifdef SRAM_REQ_CTRL_RMW_EN
    logic [ADDR_W-1:0] rmwAddr_q, rmwAddr_d;
    logic [3:0]        rmwBe_q, rmwBe_d;
    logic [31:0]       rmwWdata_q, rmwWdata_d;
    logic [31:0]       merged_q, merged_d;
`endif

    assign reqWordAddr    = bus.req_addr[ADDR_W+1:2];
    assign unusedAddrBits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

    // Reset gates acceptance so nothing is started while the block is held in reset.
    assign reqReady = (state_q == IDLE) && (!rspValid_q || bus.rsp_ready) && !reset;
    assign accept   = bus.req_valid && reqReady;

    always_comb begin
        state_d   = state_q;
        rspSet    = 1'b0;
        rspData   = 32'h0;
        rspErrSet = 1'b0;
        sramEn    = 1'b0;
        sramWen   = 4'h0;
        sramAddr  = reqWordAddr;
        sramWdata = bus.req_wdata;
`ifdef SRAM_REQ_CTRL_RMW_EN
        rmwAddr_d  = rmwAddr_q;
        rmwBe_d    = rmwBe_q;
        rmwWdata_d = rmwWdata_q;
        merged_d   = merged_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_wr) begin
                        sramEn  = 1'b1;
                        state_d = RD_WAIT;
                    end else if (bus.req_be == 4'hF) begin
                        sramWen = 4'hF;
                        rspSet  = 1'b1;
                    end else if (bus.req_be == 4'h0) begin
                        rspSet = 1'b1;
                    end else begin
`ifdef SRAM_REQ_CTRL_RMW_EN
                        sramEn     = 1'b1;
                        rmwAddr_d  = reqWordAddr;
                        rmwBe_d    = bus.req_be;
                        rmwWdata_d = bus.req_wdata;
                        state_d    = RMW_RD;
`else
                        rspSet    = 1'b1;
                        rspErrSet = 1'b1;
`endif
                    end
                end
            end
            RD_WAIT: begin
                rspSet  = 1'b1;
                rspData = bus.sram_rdata;
                state_d = IDLE;
            end
`ifdef SRAM_REQ_CTRL_RMW_EN
            RMW_RD: begin
                for (int i = 0; i < 4; i++) begin
                    merged_d[8*i +: 8] = rmwBe_q[i] ? rmwWdata_q[8*i +: 8] : bus.sram_rdata[8*i +: 8];
                end
                state_d = RMW_WR;
            end
            RMW_WR: begin
                sramWen   = 4'hF;
                sramAddr  = rmwAddr_q;
                sramWdata = merged_q;
                rspSet    = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'h0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rspSet) begin
                rspValid_q <= 1'b1;
                rspRdata_q <= rspData;
                rspErr_q   <= rspErrSet;
            end else if (bus.rsp_ready) begin
                rspValid_q <= 1'b0;
            end
        end
    end

`ifdef SRAM_REQ_CTRL_RMW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rmwAddr_q  <= '0;
            rmwBe_q    <= 4'h0;
            rmwWdata_q <= 32'h0;
            merged_q   <= 32'h0;
        end else begin
            rmwAddr_q  <= rmwAddr_d;
            rmwBe_q    <= rmwBe_d;
            rmwWdata_q <= rmwWdata_d;
            merged_q   <= merged_d;
        end
    end
`endif

    assign bus.req_ready  = reqReady;
    assign bus.rsp_valid  = rspValid_q;
    assign bus.rsp_rdata  = rspRdata_q;
    assign bus.rsp_err    = rspErr_q;
    assign bus.sram_en    = sramEn && !reset;
    assign bus.sram_wen   = reset ? 4'h0 : sramWen;
    assign bus.sram_addr  = sramAddr;
    assign bus.sram_wdata = sramWdata;

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request-side controller placed directly upstream of the team's single-port word SRAM (1-cycle registered read, full-word write on any nonzero write-enable bit). It accepts byte-enabled read/write requests over a valid/ready handshake, sequences the SRAM port, and returns one response per request. Partial-word writes are performed as read-modify-write, because the SRAM itself ignores individual byte lanes.

## Interface
- ADDR_W, 12: SRAM word-address width; byte address bits [ADDR_W+1:2] select the word.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_be  in  4  byte enables for writes, bit i = byte lane [8i+7:8i]; ignored for reads.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data, lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  read data; 0 for write responses.
- rsp_err  out  1  request was rejected (see Configuration).
- sram_en  out  1  SRAM read enable.
- sram_wen  out  4  SRAM write enable; always 4'h0 or 4'hF.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en.

## Operation
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, RSP.
- Handshake: transfer when req_valid && req_ready; req_ready = (state==IDLE) && (!rsp_valid || rsp_ready).
- Accepted read: sram_en=1, sram_addr = req_addr[ADDR_W+1:2] in the accept cycle (combinational from request) -> RD_WAIT; in RD_WAIT, capture sram_rdata into rsp_rdata and set rsp_valid -> IDLE.
- Write with req_be==4'hF: sram_wen=4'hF, sram_wdata=req_wdata in accept cycle; rsp_valid set next edge -> IDLE.
- Write with req_be==4'h0: no SRAM access; response only, rsp_err=0.
- Partial write (other be): latch addr/be/wdata; sram_en in accept cycle -> RMW_RD; in RMW_RD merge: byte i = be[i] ? wdata byte i : sram_rdata byte i, into a register -> RMW_WR; in RMW_WR, sram_wen=4'hF, sram_addr=latched, sram_wdata=merged; set rsp_valid -> IDLE.
- rsp_valid holds with stable rsp_rdata/rsp_err until rsp_ready; cleared on rsp_ready unless a new response is set the same edge.
- sram_en/sram_wen never asserted in the same cycle; both 0 in any cycle not listed above.
- RSP state is unused in normal flow; reserved, transitions to IDLE.

## Timing
- Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, internal latches 0; sram_en=0, sram_wen=0 while reset high.
- Accept at cycle T: read -> rsp_valid at T+2; full/zero-be write -> T+1; partial write -> SRAM write at T+2, rsp_valid at T+3.
- Max throughput: one read per 2 cycles, one full write per cycle when rsp_ready held high.
- Read after write to same word sees new data (writes complete before next acceptance).
- Reset asserted mid-RMW: no write issued, response discarded, return to IDLE.
- rsp_ready low: req_ready held 0; no new SRAM access started.

## Configuration
- SRAM_REQ_CTRL_RMW_EN defined: partial writes use read-modify-write as above.
- Not defined: RMW_RD/RMW_WR unreachable; partial write (be not 4'h0 or 4'hF) issues no SRAM access and returns rsp_valid at T+1 with rsp_err=1, rsp_rdata=0.

## Test plan
- Reset: hold reset 3 cycles with req_valid=1 -> rsp_valid=0, sram_en=0, sram_wen=0, req_ready rises first cycle after release.
- Write 0xDEADBEEF be=F to addr 0x10, then read 0x10 -> sram_wen=F at word 4, read rsp_rdata=0xDEADBEEF two cycles after accept.
- With RMW_EN: after above, write 0x000000AA be=4'b0001 to 0x10 -> one sram_en then sram_wen=F with 0xDEADBEAA; readback 0xDEADBEAA, response at T+3.
- Without RMW_EN: same partial write -> rsp_err=1 at T+1, no sram_en/sram_wen; readback still 0xDEADBEEF.
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, single sram_en pulse.
- Reset asserted in RMW_RD cycle -> no sram_wen pulse; memory word unchanged on later read.
